// File: rtl/bcd_clock_pkg.sv
// Shared types and helpers for the BCD alarm clock: alarm states, packed time, reset times, BCD validity.
// Latency: n/a (types and combinational functions only).
// Backpressure: none.
package bcd_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_e;

  typedef struct packed {
    logic [3:0] h_t;
    logic [3:0] h_u;
    logic [3:0] m_t;
    logic [3:0] m_u;
    logic [3:0] s_t;
    logic [3:0] s_u;
  } bcd_time_t;

  localparam bcd_time_t RESET_TIME_24H = 24'h000000;
  localparam bcd_time_t RESET_TIME_12H = 24'h120000;

  // Two-digit BCD field: units 0..9, tens 0..max_tens.
  function automatic logic bcd_pair_ok(input logic [3:0] tens, input logic [3:0] units,
                                       input logic [3:0] max_tens);
    return (tens <= max_tens) && (units <= 4'd9);
  endfunction

  // Hours field: 00..23 in 24h mode, 01..12 in 12h mode.
  function automatic logic bcd_hours_ok(input logic [3:0] h_t, input logic [3:0] h_u,
                                        input logic mode_24h);
    logic [6:0] hrs;
    hrs = {3'b000, h_t} * 7'd10 + {3'b000, h_u};
    if (!bcd_pair_ok(h_t, h_u, 4'd2)) return 1'b0;
    if (mode_24h) return hrs <= 7'd23;
    return (hrs >= 7'd1) && (hrs <= 7'd12);
  endfunction

  function automatic logic bcd_time_ok(input bcd_time_t t, input logic mode_24h);
    return bcd_pair_ok(t.m_t, t.m_u, 4'd5) && bcd_pair_ok(t.s_t, t.s_u, 4'd5) &&
           bcd_hours_ok(t.h_t, t.h_u, mode_24h);
  endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD 00..59 counter with increment/carry, parallel load and load-value check.
// Latency: value updates on the clock edge after inc/load; carry_out and cnt_nxt are combinational.
// Backpressure: none; load wins over inc.
module bcd_mod60_counter
  import bcd_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] cnt,
  output logic [7:0] cnt_nxt,
  output logic       carry_out,
  output logic       load_ok
);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  assign load_ok   = bcd_pair_ok(load_val[7:4], load_val[3:0], 4'd5);
  assign carry_out = inc && !load && (tens_q == 4'd5) && (units_q == 4'd9);
  assign cnt       = {tens_q, units_q};
  assign cnt_nxt   = {tens_d, units_d};

  // Next digit values: load, else BCD increment with 59 -> 00 wrap.
  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (load) begin
      tens_d  = load_val[7:4];
      units_d = load_val[3:0];
    end else if (inc) begin
      if (units_q == 4'd9) begin
        units_d = 4'd0;
        tens_d  = (tens_q == 4'd5) ? 4'd0 : tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  // Digit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/bcd_alarm_clock.sv
// BCD time-of-day clock (12/24h) with prescaled seconds tick, settable time and a ring/snooze alarm.
// Latency: time, sec_tick and set_err update one edge after the cause; ringing follows a match by one edge.
// Backpressure: none; every pulse input is acted on (or rejected via set_err) in the cycle it is seen.
module bcd_alarm_clock
  import bcd_clock_pkg::*;
#(
  parameter int CLK_DIV    = 1,
  parameter int MODE_24H   = 1,
  parameter int ALARM_HOLD = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_time,
  input  logic [23:0] time_in,
  input  logic        pm_in,
  input  logic        alarm_wr,
  input  logic [23:0] alarm_in,
  input  logic        alarm_pm_in,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  input  logic        snooze,
  output logic [23:0] time_out,
  output logic        pm,
  output logic        sec_tick,
  output logic        ringing,
  output logic        set_err
);

  localparam int        PW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int        SNOOZE_TICKS = SNOOZE_MIN * 60;
  localparam int        CNT_MAX      = (ALARM_HOLD > SNOOZE_TICKS) ? ALARM_HOLD : SNOOZE_TICKS;
  localparam int        CW           = $clog2(CNT_MAX + 1);
  localparam bit        MODE24       = (MODE_24H != 0);
  localparam bcd_time_t RESET_TIME   = MODE24 ? RESET_TIME_24H : RESET_TIME_12H;
  localparam logic [PW-1:0] PRE_LAST    = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(ALARM_HOLD);
  localparam logic [CW-1:0] SNOOZE_LOAD = CW'(SNOOZE_TICKS);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    hour_q, hour_d;
  logic          pm_q, pm_d;
  bcd_time_t     alarm_q, alarm_d;
  logic          alarm_pm_q, alarm_pm_d;
  logic          match_q, match_d;
  logic          sec_tick_q, set_err_q;
  alarm_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0] sec_cnt, sec_nxt, min_cnt, min_nxt;
  logic       sec_carry, min_carry, sec_ok, min_ok;
  logic       set_ok, alarm_ok, tick_raw, tick;

  // A valid load restarts the second and suppresses the coincident tick.
  assign set_ok   = set_time && sec_ok && min_ok && bcd_hours_ok(time_in[23:20], time_in[19:16], MODE24);
  assign alarm_ok = alarm_wr && bcd_time_ok(alarm_in, MODE24);
  assign tick_raw = (pre_q == PRE_LAST);
  assign tick     = tick_raw && !set_ok;

  bcd_mod60_counter u_sec (
    .clk(clk), .reset(reset), .inc(tick), .load(set_ok), .load_val(time_in[7:0]),
    .cnt(sec_cnt), .cnt_nxt(sec_nxt), .carry_out(sec_carry), .load_ok(sec_ok)
  );

  bcd_mod60_counter u_min (
    .clk(clk), .reset(reset), .inc(sec_carry), .load(set_ok), .load_val(time_in[15:8]),
    .cnt(min_cnt), .cnt_nxt(min_nxt), .carry_out(min_carry), .load_ok(min_ok)
  );

  // Prescaler: 0..CLK_DIV-1, cleared by a valid time load.
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (set_ok || tick_raw) pre_d = '0;
  end

  // Hours and pm: load, or advance on minute carry with 24h / 12h wrap rules.
  always_comb begin
    hour_d = hour_q;
    pm_d   = pm_q;
    if (set_ok) begin
      hour_d = time_in[23:16];
      pm_d   = MODE24 ? 1'b0 : pm_in;
    end else if (min_carry) begin
      if (MODE24 && hour_q == 8'h23) begin
        hour_d = 8'h00;
      end else if (!MODE24 && hour_q == 8'h12) begin
        hour_d = 8'h01;
      end else begin
        if (!MODE24 && hour_q == 8'h11) pm_d = !pm_q;
        hour_d = (hour_q[3:0] == 4'd9) ? {hour_q[7:4] + 4'd1, 4'd0} : {hour_q[7:4], hour_q[3:0] + 4'd1};
      end
    end
  end

  // Alarm register and match flag; only tick-driven updates can match, against the pre-write alarm.
  always_comb begin
    alarm_d    = alarm_q;
    alarm_pm_d = alarm_pm_q;
    if (alarm_ok) begin
      alarm_d    = alarm_in;
      alarm_pm_d = MODE24 ? 1'b0 : alarm_pm_in;
    end
    match_d = tick && alarm_en && ({hour_d, min_nxt, sec_nxt} == alarm_q) && (pm_d == alarm_pm_q);
  end

  // Alarm FSM: disable > valid alarm write > ack > snooze > counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!alarm_en || alarm_ok || alarm_ack) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (match_q) begin
            state_d = ST_RINGING;
            cnt_d   = HOLD_LOAD;
          end
        end
        ST_RINGING: begin
          if (snooze) begin
            state_d = ST_SNOOZE;
            cnt_d   = SNOOZE_LOAD;
          end else if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_SNOOZE: begin
          if (cnt_q == '0) begin
            state_d = ST_RINGING;
            cnt_d   = HOLD_LOAD;
          end else if (tick) begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      hour_q     <= {RESET_TIME.h_t, RESET_TIME.h_u};
      pm_q       <= 1'b0;
      alarm_q    <= RESET_TIME;
      alarm_pm_q <= 1'b0;
      match_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
    end else begin
      pre_q      <= pre_d;
      hour_q     <= hour_d;
      pm_q       <= pm_d;
      alarm_q    <= alarm_d;
      alarm_pm_q <= alarm_pm_d;
      match_q    <= match_d;
      sec_tick_q <= tick;
      set_err_q  <= (set_time && !set_ok) || (alarm_wr && !alarm_ok);
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign time_out = {hour_q, min_cnt, sec_cnt};
  assign pm       = pm_q;
  assign sec_tick = sec_tick_q;
  assign set_err  = set_err_q;
  assign ringing  = (state_q == ST_RINGING);

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// Bench for bcd_alarm_clock: a 24h/CLK_DIV=4 instance and a 12h/CLK_DIV=1 instance share one stimulus.
// Reference model keeps time as seconds-of-day and derives BCD/pm from it.
// Directed steps first, then a randomized phase.
module tb_bcd_alarm_clock;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        set_time = 1'b0, pm_in = 1'b0, alarm_wr = 1'b0, alarm_pm_in = 1'b0;
  logic        alarm_en = 1'b0, alarm_ack = 1'b0, snooze = 1'b0;
  logic [23:0] time_in = '0, alarm_in = '0;

  logic [23:0] time_out_a, time_out_b;
  logic        pm_a, pm_b, sec_tick_a, sec_tick_b, ringing_a, ringing_b, set_err_a, set_err_b;

  always #5 clk = ~clk;

  bcd_alarm_clock #(.CLK_DIV(4), .MODE_24H(1), .ALARM_HOLD(3), .SNOOZE_MIN(1)) dut_a (
    .clk(clk), .reset(reset), .set_time(set_time), .time_in(time_in), .pm_in(pm_in),
    .alarm_wr(alarm_wr), .alarm_in(alarm_in), .alarm_pm_in(alarm_pm_in), .alarm_en(alarm_en),
    .alarm_ack(alarm_ack), .snooze(snooze), .time_out(time_out_a), .pm(pm_a),
    .sec_tick(sec_tick_a), .ringing(ringing_a), .set_err(set_err_a)
  );

  bcd_alarm_clock #(.CLK_DIV(1), .MODE_24H(0), .ALARM_HOLD(2), .SNOOZE_MIN(1)) dut_b (
    .clk(clk), .reset(reset), .set_time(set_time), .time_in(time_in), .pm_in(pm_in),
    .alarm_wr(alarm_wr), .alarm_in(alarm_in), .alarm_pm_in(alarm_pm_in), .alarm_en(alarm_en),
    .alarm_ack(alarm_ack), .snooze(snooze), .time_out(time_out_b), .pm(pm_b),
    .sec_tick(sec_tick_b), .ringing(ringing_b), .set_err(set_err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model, index 0 = dut_a, 1 = dut_b.
  int m_div[2]  = '{4, 1};
  bit m_24[2]   = '{1'b1, 1'b0};
  int m_hold[2] = '{3, 2};
  int m_snz[2]  = '{60, 60};
  int m_pre[2], m_tod[2], m_alarm[2], m_cnt[2], m_state[2]; // state: 0 idle, 1 ringing, 2 snooze
  bit m_match[2], m_tick[2], m_err[2];

  function automatic bit valid_time(input logic [23:0] t, input bit m24);
    int h;
    h = int'(t[23:20]) * 10 + int'(t[19:16]);
    if (t[23:20] > 9 || t[19:16] > 9 || t[15:12] > 5 || t[11:8] > 9 || t[7:4] > 5 || t[3:0] > 9)
      return 1'b0;
    return m24 ? (h <= 23) : (h >= 1 && h <= 12);
  endfunction

  function automatic int decode(input logic [23:0] t, input bit p, input bit m24);
    int h, s;
    h = int'(t[23:20]) * 10 + int'(t[19:16]);
    s = (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    if (!m24) h = (h % 12) + (p ? 12 : 0);
    return h * 3600 + s;
  endfunction

  // Returns {pm, time} for a seconds-of-day value.
  function automatic logic [24:0] encode(input int tod, input bit m24);
    int h, m, s;
    bit p;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    p = 1'b0;
    if (!m24) begin
      p = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {p, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pre[i] = 0; m_tod[i] = 0; m_alarm[i] = 0; m_cnt[i] = 0; m_state[i] = 0;
      m_match[i] = 1'b0; m_tick[i] = 1'b0; m_err[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i);
    bit set_ok, al_ok, tick;
    int new_tod;
    set_ok = set_time && valid_time(time_in, m_24[i]);
    al_ok  = alarm_wr && valid_time(alarm_in, m_24[i]);
    tick   = (m_pre[i] == m_div[i] - 1) && !set_ok;
    m_pre[i] = (set_ok || m_pre[i] == m_div[i] - 1) ? 0 : m_pre[i] + 1;
    if (set_ok) new_tod = decode(time_in, pm_in, m_24[i]);
    else if (tick) new_tod = (m_tod[i] + 1) % 86400;
    else new_tod = m_tod[i];
    if (!alarm_en || al_ok || alarm_ack) m_state[i] = 0;
    else if (m_state[i] == 0) begin
      if (m_match[i]) begin m_state[i] = 1; m_cnt[i] = m_hold[i]; end
    end else if (m_state[i] == 1) begin
      if (snooze) begin m_state[i] = 2; m_cnt[i] = m_snz[i]; end
      else if (m_cnt[i] == 0) m_state[i] = 0;
      else if (tick) m_cnt[i] = m_cnt[i] - 1;
    end else begin
      if (m_cnt[i] == 0) begin m_state[i] = 1; m_cnt[i] = m_hold[i]; end
      else if (tick) m_cnt[i] = m_cnt[i] - 1;
    end
    m_match[i] = tick && alarm_en && (new_tod == m_alarm[i]);
    if (al_ok) m_alarm[i] = decode(alarm_in, alarm_pm_in, m_24[i]);
    m_tod[i]  = new_tod;
    m_tick[i] = tick;
    m_err[i]  = (set_time && !set_ok) || (alarm_wr && !al_ok);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("time_pm_a", {pm_a, time_out_a}, encode(m_tod[0], m_24[0]));
    chk("sec_tick_a", sec_tick_a, m_tick[0]);
    chk("ringing_a", ringing_a, m_state[0] == 1);
    chk("set_err_a", set_err_a, m_err[0]);
    chk("time_pm_b", {pm_b, time_out_b}, encode(m_tod[1], m_24[1]));
    chk("sec_tick_b", sec_tick_b, m_tick[1]);
    chk("ringing_b", ringing_b, m_state[1] == 1);
    chk("set_err_b", set_err_b, m_err[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step(0);
    model_step(1);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_outputs();
    #1 reset = 1'b0;
  endtask

  task automatic set_pulse(input logic [23:0] v, input logic p);
    set_time = 1'b1; time_in = v; pm_in = p;
    cycle();
    set_time = 1'b0;
  endtask

  task automatic alarm_pulse(input logic [23:0] v, input logic p);
    alarm_wr = 1'b1; alarm_in = v; alarm_pm_in = p;
    cycle();
    alarm_wr = 1'b0;
  endtask

  initial begin
    int ring_cnt;
    int sel;
    logic [24:0] v;

    #1 do_reset();
    chk("reset_time_a", time_out_a, 24'h000000);
    chk("reset_time_b", {pm_b, time_out_b}, 25'h0120000);

    // Prescaled seconds: ticks on cycles 4, 8, 12.
    repeat (12) cycle();
    chk("cdiv_time_a", time_out_a, 24'h000003);

    // 24h midnight wrap.
    set_pulse(24'h235958, 1'b0);
    repeat (8) cycle();
    chk("wrap24_a", {pm_a, time_out_a}, 25'h0000000);

    // 12h rollovers.
    set_pulse(24'h115959, 1'b0);
    cycle();
    chk("noon_b", {pm_b, time_out_b}, 25'h1120000);
    set_pulse(24'h125959, 1'b1);
    cycle();
    chk("one_pm_b", {pm_b, time_out_b}, 25'h1010000);

    // Rejected loads.
    set_pulse(24'h250000, 1'b0);
    chk("bad_hour_a", set_err_a, 1'b1);
    cycle();
    chk("err_pulse_a", set_err_a, 1'b0);
    set_pulse(24'h000000, 1'b0);
    chk("zero_hour_b", set_err_b, 1'b1);
    alarm_pulse(24'h006000, 1'b0);
    chk("bad_alarm_a", set_err_a, 1'b1);

    // Alarm ring with hold of 3 ticks.
    alarm_pulse(24'h000005, 1'b0);
    set_pulse(24'h000003, 1'b0);
    alarm_en = 1'b1;
    ring_cnt = 0;
    repeat (40) begin
      cycle();
      if (ringing_a) ring_cnt++;
    end
    chk("ring_len_a", ring_cnt, 12);

    // Ring again, acknowledge mid-ring.
    set_pulse(24'h000003, 1'b0);
    for (int k = 0; k < 40 && !ringing_a; k++) cycle();
    chk("ring_seen_a", ringing_a, 1'b1);
    cycle();
    alarm_ack = 1'b1;
    cycle();
    alarm_ack = 1'b0;
    chk("ack_a", ringing_a, 1'b0);

    // Snooze then re-ring.
    set_pulse(24'h000003, 1'b0);
    for (int k = 0; k < 40 && !ringing_a; k++) cycle();
    snooze = 1'b1;
    cycle();
    snooze = 1'b0;
    chk("snoozed_a", ringing_a, 1'b0);
    for (int k = 0; k < 400 && !ringing_a; k++) cycle();
    chk("resnooze_ring_a", ringing_a, 1'b1);

    // Reset during snooze.
    snooze = 1'b1;
    cycle();
    snooze = 1'b0;
    repeat (20) cycle();
    do_reset();
    chk("rst_mid_a", time_out_a, 24'h000000);
    ring_cnt = 0;
    repeat (300) begin
      cycle();
      if (ringing_a) ring_cnt++;
    end
    chk("no_ring_after_rst_a", ring_cnt, 0);

    // Randomized phase.
    repeat (600) begin
      sel = int'($urandom_range(0, 1));
      set_time = ($urandom_range(0, 24) == 0);
      v = encode(int'($urandom_range(0, 86399)), m_24[sel]);
      if ($urandom_range(0, 3) == 0) v[4 * $urandom_range(0, 5) +: 4] = 4'($urandom_range(6, 15));
      time_in = v[23:0];
      pm_in = v[24];
      alarm_wr = ($urandom_range(0, 29) == 0);
      v = encode((m_tod[sel] + int'($urandom_range(2, 30))) % 86400, m_24[sel]);
      alarm_in = v[23:0];
      alarm_pm_in = v[24];
      alarm_en = ($urandom_range(0, 59) != 0);
      alarm_ack = ($urandom_range(0, 49) == 0);
      snooze = ($urandom_range(0, 14) == 0);
      cycle();
    end
    set_time = 1'b0; alarm_wr = 1'b0; alarm_ack = 1'b0; snooze = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_alarm_clock.md
Name: bcd_alarm_clock

Overview:
Parametrised BCD time-of-day clock with a prescaled seconds tick, selectable 12/24-hour mode, runtime time load, and a programmable alarm. The alarm has ring, snooze and acknowledge control.
Sits between the board clock domain and the display/LED logic. It drives packed BCD digits plus a ringing flag.
Successor to the fixed 24-hour-per-cycle counter. Adds prescaling, 12h mode, settable time, a stored alarm register, timed ringing and snooze.

Parameters:
CLK_DIV, 1, clk cycles per second tick (>=1); 1 = advance every cycle
MODE_24H, 1, 1 = 00..23 hours; 0 = 12,01..11 hours with pm flag
ALARM_HOLD, 60, seconds ringing stays asserted before auto-clear (>=1)
SNOOZE_MIN, 5, snooze duration in minutes (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
set_time  in  1  pulse; load time_in/pm_in
time_in  in  24  BCD {h_t[3:0],h_u,m_t,m_u,s_t,s_u}
pm_in  in  1  pm bit for load (ignored when MODE_24H=1)
alarm_wr  in  1  pulse; load alarm_in/alarm_pm_in into alarm register
alarm_in  in  24  alarm time, same packing
alarm_pm_in  in  1  alarm pm bit (ignored when MODE_24H=1)
alarm_en  in  1  level; alarm armed
alarm_ack  in  1  pulse; stop ringing/snooze
snooze  in  1  pulse; snooze while ringing
time_out  out  24  current time, BCD packed
pm  out  1  pm flag (always 0 when MODE_24H=1)
sec_tick  out  1  one-cycle pulse, registered, coincident with time_out update
ringing  out  1  alarm active
set_err  out  1  one-cycle pulse: rejected set_time/alarm_wr

Behaviour:
- Reset (async): prescaler=0; time_out=000000 (24h) or 120000 with pm=0 (12h); alarm register = same value; state IDLE; sec_tick=0, ringing=0, set_err=0.
- Prescaler: counts 0..CLK_DIV-1. The tick fires when it equals CLK_DIV-1, then wraps to 0. Width is max(1,$clog2(CLK_DIV)).
- On tick, time advances one second. The new value appears in time_out the same edge sec_tick is asserted.
- Seconds and minutes wrap 59->00 with carry. 24h: 23:59:59 -> 00:00:00.
- 12h: 11:59:59 -> 12:00:00 and pm toggles; 12:59:59 -> 01:00:00 with pm unchanged.
- set_time: validity check applies. Each digit must be BCD <=9; tens of m/s <=5; hours 00..23 (24h) or 01..12 (12h).
  - Valid: time_out and pm load next edge; prescaler clears to 0; no tick that cycle.
  - Invalid: no change; set_err pulses.
  - set_time has priority over a coincident tick.
- alarm_wr: same validation, same set_err behaviour. A valid write in RINGING/SNOOZE forces IDLE.
- Match: registered flag, true one cycle after a tick-driven update where alarm_en=1 and {time_out,pm} equals the alarm register. A set_time landing on the alarm value never matches.
- FSM states IDLE, RINGING, SNOOZE. ringing=1 only in RINGING (registered, from state).
  - IDLE -> RINGING on match; hold counter loads ALARM_HOLD.
  - RINGING: decrement on each tick. Go to IDLE when it reaches 0 or on alarm_ack. snooze -> SNOOZE with counter loaded to SNOOZE_MIN*60.
  - SNOOZE: decrement on each tick; at 0 -> RINGING (hold reloads). alarm_ack -> IDLE.
  - Priority: alarm_en=0 > valid alarm_wr > alarm_ack > snooze > counter expiry. alarm_en=0 forces IDLE from any state next edge.
  - A match while in RINGING/SNOOZE is ignored.
- Reset mid-operation returns everything to reset values immediately.

Decomposition:
- Package bcd_clock_pkg:
  - state enum typedef (IDLE/RINGING/SNOOZE)
  - packed bcd_time_t struct (six 4-bit digits)
  - reset-time localparams for each mode
  - bcd validity function
- Sub-module bcd_mod60_counter: two-digit 00..59 with inc/carry_out, load and valid-check. Instantiated for seconds and minutes. Hours logic stays in the top.

Test Plan:
- CLK_DIV=4, reset, run 12 cycles -> sec_tick on cycles 4,8,12; time_out 000001, 000002, 000003.
- 24h, set_time 235958, two ticks -> 235959 then 000000, pm=0.
- 12h: set 115959 pm=0, tick -> 120000 pm=1; set 125959 pm=1, tick -> 010000 pm=1.
- set_time 250000 (24h) or 000000 (12h) -> set_err one cycle, time_out unchanged; alarm_wr 006000 -> set_err.
- Alarm 000005, set 000003, alarm_en=1, ALARM_HOLD=3.
  - ringing rises one cycle after time_out=000005 and falls one cycle after the third subsequent tick.
  - A repeat with alarm_ack mid-ring drops ringing the next edge.
- Snooze path with SNOOZE_MIN=1:
  - snooze while ringing -> ringing=0 for 60 ticks, then re-asserts.
  - Reset asserted during SNOOZE -> ringing=0, time_out reset value, no later ring.
